gpio0_clkin_poller: RTL and testbench
=====================================

# gpio0_clkin_poller

Polling controller for the two-bit clock-input PIO slave: it is the only master on that slave. It reads the PIO data register at a fixed rate, detects rising edges on each of the two inputs, and counts them over a programmable gate window. It exposes the results to the Nios CPU through its own Avalon-MM slave with an optional window-done interrupt. Typical use is coarse frequency and activity measurement of the external clock inputs.

## Interface
- POLL_DIV, 50: clock cycles per poll; legal range ≥3.
- GATE_POLLS, 1000: polls per gate window; legal range ≥2.
- CNT_W, 16: edge-counter width, 1..32.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pio_address  out  2  address to the PIO slave; 0 only in ISSUE, parked at 1 otherwise
- pio_readdata  in  2  PIO read data; registered by the slave, valid one cycle after address 0
- s_address  in  2  CPU register select
- s_read  in  1  CPU read strobe
- s_write  in  1  CPU write strobe
- s_writedata  in  32  CPU write data
- s_readdata  out  32  CPU read data, registered, 1-cycle latency
- irq  out  1  done & irq_en

## Operation
- Registers (CPU slave):
  - 0 CTRL, R/W. bit0 enable, bit1 irq_en; other bits read 0.
  - 1 STATUS. bit0 done: sticky; a write with bit0=1 clears it. bits[3:2] hold the last captured sample {ch1,ch0}. All other bits read 0, and writes to them are ignored.
  - 2 COUNT0, RO. Channel 0 rising edges in the last completed window, zero-extended.
  - 3 COUNT1, RO. Same as COUNT0, for channel 1.
- FSM states: IDLE, ISSUE, CAPTURE, WAIT.
  - IDLE: live counters, poll counter and first-sample flag are cleared; pio_address=1. Moves to ISSUE when enable=1.
  - ISSUE: one cycle with pio_address=0. Always moves to CAPTURE.
  - CAPTURE: registers pio_readdata as the new sample.
    - Computes rise = new & ~prev per channel.
    - Skips edge counting on the first capture after leaving IDLE; that capture only initialises prev.
    - Otherwise each live counter increments on its rise bit and saturates at 2^CNT_W−1.
    - Increments the poll counter and updates STATUS[3:2].
    - Moves to WAIT.
  - WAIT: lasts POLL_DIV−2 cycles, then moves to ISSUE.
- Window end: when the CAPTURE is poll number GATE_POLLS of the window (the non-counting first capture is included in the count):
  - COUNTx ← live counter including this capture's increment.
  - Live counters and the poll counter go to 0; done ← 1.
  - The next window starts with the next ISSUE. prev is retained, so no sample is skipped.
- When enable=0 is observed in any non-IDLE state, the FSM moves to IDLE on the next edge and any in-flight capture is discarded. COUNTx and done are retained.
- Writes to CTRL take effect the edge after the write cycle.

## Timing
- Reset values:
  - state IDLE, pio_address=1, s_readdata=0, irq=0.
  - CTRL=0, done=0, sample=0, COUNTx=0, all live counters 0.
- Poll period is exactly POLL_DIV cycles: ISSUE cycles occur at t, t+POLL_DIV, and so on.
- After CTRL.enable is written in cycle W, the first ISSUE is in cycle W+2.
- pio_readdata is sampled in the cycle immediately after ISSUE and reflects in_port as registered at the end of ISSUE.
- s_readdata is updated on the edge after an s_read cycle and holds its value otherwise. A read in the window-end CAPTURE cycle returns the previous COUNTx.
- done set and W1C clear in the same cycle: set wins.
- irq is combinational from registered done and irq_en, with no extra latency beyond the register update.
- reset asserted mid-window: all state returns to its reset values immediately (asynchronous).

## Test plan
- Reset and idle behaviour: assert reset mid-poll.
  - During reset: pio_address=1, s_readdata=0, irq=0.
  - After release, with enable=0 for 100 cycles: pio_address never 0.
- Basic window: POLL_DIV=4, GATE_POLLS=8, PIO model toggles ch0 each poll starting at 0, ch1 held at 1, enable=1, irq_en=1.
  - pio_address=0 exactly once every 4 cycles.
  - After 8 captures: COUNT0=4, COUNT1=0, done=1, irq=1.
- Saturation: CNT_W=4, GATE_POLLS=40, ch1 toggles each poll.
  - COUNT1=15 rather than 20.
- Abort and restart: disable after 5 polls.
  - pio_address parks at 1 from the next cycle; COUNTx unchanged; done unchanged.
  - Re-enable: the first ISSUE is 2 cycles after the write, and a full 8-poll window is needed for the next done.
- Collision: a W1C to STATUS in the same cycle as the window-end CAPTURE leaves done=1.
  - A second W1C clears done and drops irq on the next edge.
- Read latency: s_read on address 3 in cycle N gives s_readdata valid in N+1.
  - A read issued in the window-end cycle returns the old COUNT1; a read one cycle later returns the new value.

Source files
------------

// File: rtl/gpio0_clkin_poller.sv
// Polls the two-bit clock-input PIO at a fixed rate, counts rising edges per channel
// over a gate window of polls, and exposes the results through a small CPU register slave.
module gpio0_clkin_poller #(
    parameter int POLL_DIV   = 50,
    parameter int GATE_POLLS = 1000,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  pio_address,
    input  logic [1:0]  pio_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int WAIT_W = $clog2(POLL_DIV);
    localparam int POLL_W = $clog2(GATE_POLLS + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_DIV - 3);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(GATE_POLLS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_enable;
    logic               r_irq_en;
    logic               r_done;
    logic [1:0]         r_sample;
    logic               r_first;
    logic [WAIT_W-1:0]  r_wait;
    logic [POLL_W-1:0]  r_poll;
    logic [CNT_W-1:0]   r_live0;
    logic [CNT_W-1:0]   r_live1;
    logic [CNT_W-1:0]   r_count0;
    logic [CNT_W-1:0]   r_count1;

    logic [1:0]         w_rise;
    logic               w_inc0;
    logic               w_inc1;
    logic [CNT_W-1:0]   w_live0_nxt;
    logic [CNT_W-1:0]   w_live1_nxt;
    logic               w_cap;
    logic               w_win_end;
    logic               w_ctrl_wr;
    logic               w_done_clr;
    logic [31:0]        w_cnt0_ext;
    logic [31:0]        w_cnt1_ext;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_unused = &{1'b0, s_writedata[31:2]};

    // ------------------------------------------------------------------
    // Poll sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        pio_address = 2'd1;
        case (r_state)
            S_IDLE: begin
                if (r_enable) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                pio_address = 2'd0;
                w_state_nxt = r_enable ? S_CAPTURE : S_IDLE;
            end
            S_CAPTURE: begin
                w_state_nxt = r_enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!r_enable)               w_state_nxt = S_IDLE;
                else if (r_wait == WAIT_LAST) w_state_nxt = S_ISSUE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A capture seen with enable low is dropped: the FSM is leaving for IDLE.
    assign w_cap     = (r_state == S_CAPTURE) && r_enable;
    assign w_win_end = (r_poll == POLL_LAST);

    assign w_rise = pio_readdata & ~r_sample;
    assign w_inc0 = !r_first && w_rise[0] && (r_live0 != CNT_MAX);
    assign w_inc1 = !r_first && w_rise[1] && (r_live1 != CNT_MAX);
    assign w_live0_nxt = r_live0 + CNT_W'(w_inc0);
    assign w_live1_nxt = r_live1 + CNT_W'(w_inc1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Sampling and edge counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= '0;
            r_first  <= 1'b1;
            r_poll   <= '0;
            r_live0  <= '0;
            r_live1  <= '0;
            r_count0 <= '0;
            r_count1 <= '0;
        end else if (r_state == S_IDLE) begin
            r_first <= 1'b1;
            r_poll  <= '0;
            r_live0 <= '0;
            r_live1 <= '0;
        end else if (w_cap) begin
            r_sample <= pio_readdata;
            r_first  <= 1'b0;
            // prev sample survives the window boundary so no edge is lost
            if (w_win_end) begin
                r_count0 <= w_live0_nxt;
                r_count1 <= w_live1_nxt;
                r_live0  <= '0;
                r_live1  <= '0;
                r_poll   <= '0;
            end else begin
                r_live0 <= w_live0_nxt;
                r_live1 <= w_live1_nxt;
                r_poll  <= r_poll + POLL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU register slave
    // ------------------------------------------------------------------
    assign w_ctrl_wr  = s_write && (s_address == 2'd0);
    assign w_done_clr = s_write && (s_address == 2'd1) && s_writedata[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_enable <= s_writedata[0];
            r_irq_en <= s_writedata[1];
        end
    end

    // Window completion beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_done <= 1'b0;
        else if (w_cap && w_win_end) r_done <= 1'b1;
        else if (w_done_clr)         r_done <= 1'b0;
    end

    always_comb begin
        w_cnt0_ext = '0;
        w_cnt1_ext = '0;
        w_cnt0_ext[CNT_W-1:0] = r_count0;
        w_cnt1_ext[CNT_W-1:0] = r_count1;
    end

    always_comb begin
        w_rdata = '0;
        case (s_address)
            2'd0: w_rdata = {30'd0, r_irq_en, r_enable};
            2'd1: w_rdata = {28'd0, r_sample, 1'b0, r_done};
            2'd2: w_rdata = w_cnt0_ext;
            2'd3: w_rdata = w_cnt1_ext;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       s_readdata <= '0;
        else if (s_read) s_readdata <= w_rdata;
    end

    assign irq = r_done && r_irq_en;

endmodule

// File: tb/tb_gpio0_clkin_poller.sv
// Scoreboard bench: read expectations are queued at issue time and checked by a
// monitor when read data becomes valid; two instances cover the window and saturation cases.
module tb_gpio0_clkin_poller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main instance: POLL_DIV=4, GATE_POLLS=8, CNT_W=16
    logic [1:0]  pio_address, pio_readdata, s_address;
    logic        s_read, s_write, irq;
    logic [31:0] s_writedata, s_readdata;
    // saturation instance: POLL_DIV=4, GATE_POLLS=40, CNT_W=4
    logic [1:0]  t_pio_address, t_pio_readdata, t_address;
    logic        t_read, t_write, t_irq;
    logic [31:0] t_writedata, t_readdata;

    gpio0_clkin_poller #(.POLL_DIV(4), .GATE_POLLS(8), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .pio_address(pio_address), .pio_readdata(pio_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
    );

    gpio0_clkin_poller #(.POLL_DIV(4), .GATE_POLLS(40), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .pio_address(t_pio_address), .pio_readdata(t_pio_readdata),
        .s_address(t_address), .s_read(t_read), .s_write(t_write),
        .s_writedata(t_writedata), .s_readdata(t_readdata), .irq(t_irq)
    );

    // PIO slave models: registered read data, input toggles once per poll
    logic ph0, ph1, clr_ph;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_readdata <= 2'b00;
            ph0 <= 1'b0;
        end else if (clr_ph) begin
            ph0 <= 1'b0;
        end else if (pio_address == 2'd0) begin
            pio_readdata <= {1'b1, ph0};
            ph0 <= ~ph0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_pio_readdata <= 2'b00;
            ph1 <= 1'b0;
        end else if (t_pio_address == 2'd0) begin
            t_pio_readdata <= {ph1, 1'b0};
            ph1 <= ~ph1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // scoreboards
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [31:0] texp_q[$];
    string       tnm_q[$];
    logic        rd_pend = 1'b0;
    logic        trd_pend = 1'b0;

    always @(posedge clk) begin
        rd_pend  <= s_read;
        trd_pend <= t_read;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main_unexpected_read: got 0x%0h expected none", s_readdata);
            end else begin
                chk(nm_q.pop_front(), s_readdata, exp_q.pop_front());
            end
        end
        if (trd_pend) begin
            if (texp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sat_unexpected_read: got 0x%0h expected none", t_readdata);
            end else begin
                chk(tnm_q.pop_front(), t_readdata, texp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_write = 1'b1;
        tick();
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        s_address = a; s_read = 1'b1;
        exp_q.push_back(e); nm_q.push_back(nm);
        tick();
        s_read = 1'b0;
    endtask

    task automatic twr(input logic [1:0] a, input logic [31:0] d);
        t_address = a; t_writedata = d; t_write = 1'b1;
        tick();
        t_write = 1'b0;
    endtask

    task automatic trd(input logic [1:0] a, input logic [31:0] e, input string nm);
        t_address = a; t_read = 1'b1;
        texp_q.push_back(e); tnm_q.push_back(nm);
        tick();
        t_read = 1'b0;
    endtask

    initial begin
        int nz;
        s_address = 2'd0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        t_address = 2'd0; t_read = 1'b0; t_write = 1'b0; t_writedata = '0;
        clr_ph = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset asserted in the middle of an ISSUE cycle
        wr(2'd0, 32'h3);
        rd(2'd0, 32'h3, "ctrl_readback");
        repeat (4) tick();
        chk("pre_reset_issue", {30'd0, pio_address}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("reset_pio_address", {30'd0, pio_address}, 32'd1);
        chk("reset_readdata", s_readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        rd(2'd0, 32'h0, "ctrl_after_reset");
        rd(2'd1, 32'h0, "status_after_reset");
        rd(2'd2, 32'h0, "count0_after_reset");

        nz = 0;
        repeat (100) begin
            if (pio_address == 2'd0) nz++;
            tick();
        end
        chk("idle_no_issue", nz, 0);

        // basic window: ch0 toggles 0,1,0,..., ch1 held high
        wr(2'd0, 32'h3);
        chk("enable_plus1_parked", {30'd0, pio_address}, 32'd1);
        for (int i = 1; i <= 29; i++) begin
            tick();
            chk($sformatf("poll_addr_%0d", i), {30'd0, pio_address},
                ((i - 1) % 4 == 0) ? 32'd0 : 32'd1);
        end
        chk("irq_before_window_end", {31'd0, irq}, 32'd0);
        tick();
        rd(2'd2, 32'd0, "count0_read_in_end_cycle");
        chk("irq_after_window", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'd4, "count0_read_after_end");
        rd(2'd3, 32'd0, "count1_window1");
        rd(2'd1, 32'd13, "status_window1");

        // abort five polls into the next window
        repeat (17) tick();
        wr(2'd0, 32'h2);
        nz = 0;
        repeat (20) begin
            if (pio_address == 2'd0) nz++;
            tick();
        end
        chk("abort_parked", nz, 0);
        chk("abort_irq_kept", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'd4, "abort_count0_kept");
        rd(2'd3, 32'd0, "abort_count1_kept");
        rd(2'd1, 32'd9, "abort_status_kept");
        wr(2'd1, 32'h1);
        chk("w1c_irq_low", {31'd0, irq}, 32'd0);

        // restart: needs a full window, with a W1C colliding with window end
        clr_ph = 1'b1;
        tick();
        clr_ph = 1'b0;
        wr(2'd0, 32'h3);
        chk("restart_plus1_parked", {30'd0, pio_address}, 32'd1);
        tick();
        chk("restart_plus2_issue", {30'd0, pio_address}, 32'd0);
        repeat (28) tick();
        chk("restart_no_early_done", {31'd0, irq}, 32'd0);
        tick();
        wr(2'd1, 32'h1);
        chk("collision_done_wins", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'h1);
        chk("second_w1c_clears", {31'd0, irq}, 32'd0);
        rd(2'd1, 32'd12, "status_after_clear");
        rd(2'd2, 32'd4, "count0_restart_window");
        rd(2'd3, 32'd0, "count1_restart_window");
        wr(2'd0, 32'h0);

        // saturation: 20 rising edges on ch1 into a 4-bit counter
        twr(2'd0, 32'h1);
        repeat (159) tick();
        trd(2'd3, 32'd15, "sat_count1");
        trd(2'd2, 32'd0, "sat_count0");
        trd(2'd1, 32'd9, "sat_status");

        tick();
        tick();
        chk("scoreboard_drained", exp_q.size() + texp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
